// File: rtl/bcd_frame_tx.sv
// Serial transmitter: accepts a BCD operand set over valid/ready and shifts out one
// 41-bit frame {sync, control, A, B} MSB-first, followed by an optional idle gap.
module bcd_frame_tx #(
  parameter logic [7:0] SYNC_PATTERN = 8'b01011010,
  parameter int         GAP_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        control,
  input  logic [15:0] input_a,
  input  logic [15:0] input_b,
  output logic        dout,
  output logic        dout_valid,
  output logic        frame_done,
  output logic        bcd_error
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  logic [1:0]  state;
  logic [40:0] shreg;
  logic [5:0]  bit_cnt;
  logic [3:0]  gap_cnt;
  logic        accept;
  logic        bad_bcd;

  function automatic logic has_bad_digit(input logic [15:0] v);
    return (v[15:12] >= 4'd10) || (v[11:8] >= 4'd10) ||
           (v[7:4]   >= 4'd10) || (v[3:0]  >= 4'd10);
  endfunction

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid & in_ready;
  assign bad_bcd  = has_bad_digit(input_a) | has_bad_digit(input_b);

  // bit_cnt holds the index of the frame bit currently on dout; shreg holds the bits still to go.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
      bcd_error  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      bcd_error  <= 1'b0;
      case (state)
        ST_IDLE: begin
          dout       <= 1'b0;
          dout_valid <= 1'b0;
          if (accept) begin
            if (bad_bcd) begin
              bcd_error <= 1'b1;
            end else begin
              shreg      <= {SYNC_PATTERN[6:0], control, input_a, input_b, 1'b0};
              dout       <= SYNC_PATTERN[7];
              dout_valid <= 1'b1;
              bit_cnt    <= 6'd40;
              state      <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          if (bit_cnt != 6'd0) begin
            dout       <= shreg[40];
            shreg      <= {shreg[39:0], 1'b0};
            bit_cnt    <= bit_cnt - 6'd1;
            frame_done <= (bit_cnt == 6'd1);
          end else begin
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            shreg      <= '0;
            if (GAP_CYCLES > 0) begin
              gap_cnt <= GAP_LOAD;
              state   <= ST_GAP;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          dout       <= 1'b0;
          dout_valid <= 1'b0;
          if (gap_cnt == 4'd0) state <= ST_IDLE;
          else gap_cnt <= gap_cnt - 4'd1;
        end
        default: begin
          state      <= ST_IDLE;
          dout       <= 1'b0;
          dout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_frame_tx.sv
// Directed bench for bcd_frame_tx: vector table plus hand sequences for back-to-back,
// mid-frame reset and a zero-gap build.
module tb_bcd_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, control;
  logic [15:0] input_a, input_b;
  logic        in_ready, dout, dout_valid, frame_done, bcd_error;

  logic        in_valid0, control0;
  logic [15:0] input_a0, input_b0;
  logic        in_ready0, dout0, dout_valid0, frame_done0, bcd_error0;

  bcd_frame_tx #(.GAP_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .control(control), .input_a(input_a), .input_b(input_b),
    .dout(dout), .dout_valid(dout_valid), .frame_done(frame_done), .bcd_error(bcd_error)
  );

  bcd_frame_tx #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .control(control0), .input_a(input_a0), .input_b(input_b0),
    .dout(dout0), .dout_valid(dout_valid0), .frame_done(frame_done0), .bcd_error(bcd_error0)
  );

  logic sel;
  wire  s_dout       = sel ? dout0       : dout;
  wire  s_dout_valid = sel ? dout_valid0 : dout_valid;
  wire  s_frame_done = sel ? frame_done0 : frame_done;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        ctrl;
    logic [15:0] a;
    logic [15:0] b;
    logic        err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Samples 41 consecutive cycles, starting at the current negedge.
  task automatic collect(output logic [40:0] frm, output int nvalid, output int done_bad);
    frm = '0; nvalid = 0; done_bad = 0;
    for (int i = 0; i < 41; i++) begin
      if (i > 0) @(negedge clk);
      frm = {frm[39:0], s_dout};
      if (s_dout_valid === 1'b1) nvalid++;
      if (s_frame_done !== (i == 40)) done_bad++;
    end
  endtask

  task automatic check_frame(input string tag, input logic [40:0] frm, input int nvalid,
                             input int done_bad, input logic c, input logic [15:0] a,
                             input logic [15:0] b);
    chk({tag, "_hdr"},   frm[40:33], 8'h5A);
    chk({tag, "_ctrl"},  frm[32], c);
    chk({tag, "_a"},     frm[31:16], a);
    chk({tag, "_b"},     frm[15:0], b);
    chk({tag, "_nvld"},  nvalid, 41);
    chk({tag, "_done"},  done_bad, 0);
  endtask

  // One-cycle offer on the GAP_CYCLES=1 instance, full frame plus gap/ready checks.
  task automatic run_legal(input string tag, input logic c, input logic [15:0] a,
                           input logic [15:0] b);
    logic [40:0] frm;
    int nv, db;
    @(negedge clk);
    chk({tag, "_rdy_pre"}, in_ready, 1'b1);
    control = c; input_a = a; input_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; control = ~c; input_a = 16'hAAAA; input_b = 16'h5555;
    collect(frm, nv, db);
    check_frame(tag, frm, nv, db, c, a, b);
    @(negedge clk);
    chk({tag, "_gap_dv"},  dout_valid, 1'b0);
    chk({tag, "_gap_rdy"}, in_ready, 1'b0);
    @(negedge clk);
    chk({tag, "_rdy_post"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [40:0] frm;
    int nv, db, cnt;

    vecs[0] = '{1'b0, 16'h1234, 16'h0567, 1'b0};
    vecs[1] = '{1'b1, 16'h9999, 16'h0000, 1'b0};
    vecs[2] = '{1'b0, 16'h12A4, 16'h0000, 1'b1};
    vecs[3] = '{1'b0, 16'h0000, 16'hF000, 1'b1};
    vecs[4] = '{1'b1, 16'h0909, 16'h9090, 1'b0};
    vecs[5] = '{1'b0, 16'h000A, 16'h0000, 1'b1};
    vecs[6] = '{1'b1, 16'h0000, 16'h0009, 1'b0};

    sel = 1'b0;
    reset = 1'b1;
    in_valid = 1'b0; control = 1'b0; input_a = '0; input_b = '0;
    in_valid0 = 1'b0; control0 = 1'b0; input_a0 = '0; input_b0 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready",  in_ready, 1'b1);
    chk("rst_dout",   dout, 1'b0);
    chk("rst_dvld",   dout_valid, 1'b0);
    chk("rst_done",   frame_done, 1'b0);
    chk("rst_err",    bcd_error, 1'b0);
    chk("rst_ready0", in_ready0, 1'b1);

    for (int i = 0; i < 7; i++) begin
      if (!vecs[i].err) begin
        run_legal($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b);
      end else begin
        @(negedge clk);
        control = vecs[i].ctrl; input_a = vecs[i].a; input_b = vecs[i].b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("vec%0d_err", i),   bcd_error, 1'b1);
        chk($sformatf("vec%0d_dvld", i),  dout_valid, 1'b0);
        chk($sformatf("vec%0d_rdy", i),   in_ready, 1'b1);
        cnt = 0;
        repeat (3) begin
          @(negedge clk);
          if (bcd_error === 1'b1 || dout_valid === 1'b1 || in_ready !== 1'b1) cnt++;
        end
        chk($sformatf("vec%0d_quiet", i), cnt, 0);
      end
    end

    // Illegal set immediately replaced by a legal one while in_valid stays high.
    @(negedge clk);
    control = 1'b0; input_a = 16'h12A4; input_b = 16'h0000; in_valid = 1'b1;
    @(negedge clk);
    input_a = 16'h1234; input_b = 16'h0567;
    chk("ill_err", bcd_error, 1'b1);
    chk("ill_dvld", dout_valid, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    collect(frm, nv, db);
    check_frame("ill_next", frm, nv, db, 1'b0, 16'h1234, 16'h0567);
    repeat (2) @(negedge clk);

    // Back-to-back with in_valid held, GAP_CYCLES=1.
    @(negedge clk);
    control = 1'b1; input_a = 16'h4321; input_b = 16'h8765; in_valid = 1'b1;
    @(negedge clk);
    control = 1'b0; input_a = 16'h2468; input_b = 16'h1357;
    collect(frm, nv, db);
    check_frame("b2b_1", frm, nv, db, 1'b1, 16'h4321, 16'h8765);
    @(negedge clk);
    chk("b2b_gap_dv", dout_valid, 1'b0);
    chk("b2b_gap_rdy", in_ready, 1'b0);
    @(negedge clk);
    chk("b2b_acc_rdy", in_ready, 1'b1);
    chk("b2b_acc_dv", dout_valid, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; input_a = 16'hFFFF;
    collect(frm, nv, db);
    check_frame("b2b_2", frm, nv, db, 1'b0, 16'h2468, 16'h1357);
    repeat (2) @(negedge clk);

    // Async reset while bit 20 is on the line.
    @(negedge clk);
    control = 1'b1; input_a = 16'h5555; input_b = 16'h7777; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_pre_dv", dout_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_dout", dout, 1'b0);
    chk("mid_rst_dv", dout_valid, 1'b0);
    chk("mid_rst_done", frame_done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rel_rdy", in_ready, 1'b1);
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (dout_valid === 1'b1 || frame_done === 1'b1) cnt++;
    end
    chk("mid_no_resume", cnt, 0);
    run_legal("post_rst", 1'b0, 16'h8080, 16'h0101);

    // GAP_CYCLES=0 instance: consecutive frames, first bits 42 cycles apart.
    sel = 1'b1;
    @(negedge clk);
    control0 = 1'b1; input_a0 = 16'h3141; input_b0 = 16'h5926; in_valid0 = 1'b1;
    @(negedge clk);
    control0 = 1'b0; input_a0 = 16'h2718; input_b0 = 16'h2818;
    collect(frm, nv, db);
    check_frame("g0_1", frm, nv, db, 1'b1, 16'h3141, 16'h5926);
    @(negedge clk);
    chk("g0_acc_dv", dout_valid0, 1'b0);
    chk("g0_acc_rdy", in_ready0, 1'b1);
    @(negedge clk);
    in_valid0 = 1'b0; control0 = 1'b1; input_a0 = 16'h0000; input_b0 = 16'h9999;
    collect(frm, nv, db);
    check_frame("g0_2", frm, nv, db, 1'b0, 16'h2718, 16'h2818);
    @(negedge clk);
    chk("g0_end_rdy", in_ready0, 1'b1);
    chk("g0_end_dv", dout_valid0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bcd_frame_tx.md
Name: bcd_frame_tx

Overview:
Serial frame transmitter for the BCD operand link; it is the sending end that feeds the serial sequence detector / BCD arithmetic receiver. It accepts a parallel operand set (control bit, BCD operand A, BCD operand B) over a valid/ready handshake and checks every digit is legal BCD. It then shifts out one 41-bit frame MSB-first on a single-bit line: 8-bit sync pattern, 1 control bit, 16-bit A, 16-bit B.

Parameters:
SYNC_PATTERN, 8'b01011010, header sent first, MSB first.
GAP_CYCLES, 1, idle cycles (dout=0) forced after each frame before next accept; legal range 0..15.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  operand set on control/input_a/input_b is valid.
in_ready  output  1  block can accept; transfer occurs on the rising edge where in_valid & in_ready.
control  input  1  0 = add, 1 = subtract; transmitted as the frame's control bit.
input_a  input  16  operand A, 4 BCD digits, [15:12] most significant.
input_b  input  16  operand B, 4 BCD digits.
dout  output  1  serial data, registered.
dout_valid  output  1  high on every cycle dout carries a frame bit.
frame_done  output  1  one-cycle pulse, coincident with the last frame bit.
bcd_error  output  1  one-cycle pulse when an offered operand set is rejected.

Behaviour:
- Reset (async, immediate): state IDLE, frame shift register 0, bit counter 0, gap counter 0. dout=0, dout_valid=0, frame_done=0, bcd_error=0. in_ready=1 as soon as reset deasserts.
- Reset mid-frame aborts the frame: no further bits, no frame_done. Resume in IDLE.
- in_ready is 1 only in IDLE. It is decoded from state; no combinational path from in_valid.
- BCD check on the accept edge: any nibble of input_a or input_b > 9 means reject.
  - Reject: bcd_error pulses the next cycle, nothing is transmitted, state stays IDLE, in_ready stays 1.
- Legal accept: load frame = {SYNC_PATTERN, control, input_a, input_b} (41 bits) and go to SEND.
  - The first bit (SYNC_PATTERN[7]) appears on dout with dout_valid=1 in the cycle right after the accept edge.
- SEND: one bit per cycle, MSB first, for exactly 41 consecutive cycles with no bubbles.
  - Bit order: header bits 40..33, control at bit 32, A at 31..16, B at 15..0.
  - 6-bit counter 40 down to 0.
  - frame_done=1 during the cycle dout carries bit 0.
- After the last bit:
  - GAP_CYCLES>0: enter GAP with dout=0, dout_valid=0, in_ready=0 for GAP_CYCLES cycles, then IDLE.
  - GAP_CYCLES=0: go directly to IDLE. The minimum frame-to-frame spacing is then 42 cycles: 41 bits plus 1 IDLE accept cycle.
- Outside SEND: dout=0 and dout_valid=0.
- Inputs are sampled only on the accept edge. Changes to control/input_a/input_b during SEND or GAP do not affect the frame in flight.
- in_valid asserted while in_ready=0 is ignored, not queued. The source must hold it until accepted.
- States: IDLE -> SEND on legal accept. SEND -> GAP, or SEND -> IDLE when GAP_CYCLES=0, after bit 0. GAP -> IDLE when the gap counter expires.
- Illegal state encodings recover to IDLE on the next edge.
- No arithmetic on operands; BCD check is a per-nibble comparison (nibble >= 4'd10).

Test Plan:
1. Basic frame, defaults: control=0, A=16'h1234, B=16'h0567, in_valid 1 cycle.
   - dout_valid is high 41 cycles starting the cycle after accept.
   - Serial stream = 01011010 0 0001001000110100 0000010101100111.
   - frame_done aligns with the final 1. in_ready returns high 2 cycles after the last bit.
2. Subtract frame: control=1, A=16'h9999, B=16'h0000.
   - Bit 32 = 1, next 16 bits are 1001 repeated, last 16 bits are 0.
   - Receiver model decodes control=1, A=9999, B=0000.
3. Illegal BCD: A=16'h12A4 or B=16'hF000.
   - bcd_error pulses once, dout_valid never rises, in_ready stays 1.
   - A following legal set is accepted on the next edge.
4. Back-to-back with in_valid held high, GAP_CYCLES=1: two legal sets.
   - Frames separated by exactly 1 gap cycle plus 1 accept cycle.
   - The second set stays pending while in_ready=0 and is sent unmodified.
5. Async reset asserted during bit 20 of a frame.
   - dout and dout_valid go 0 immediately; no frame_done.
   - After release, in_ready=1, and a new frame transmits correctly from header bit 7.
6. GAP_CYCLES=0 build, two frames back-to-back.
   - Second header bit appears 42 cycles after the first.
   - Inputs changed mid-frame do not alter the transmitted bits.
